// File: rtl/mem_loader_if.sv
// Bundle connecting mem_loader to its byte-stream host and memory data port.
// The master modport is the loader's view of the bundle. The slave modport is the host/memory view.
interface mem_loader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   word_count;
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  regWE;
   logic [ADDR_WIDTH-1:0] DataAddr;
   logic [DATA_WIDTH-1:0] DataIn;
   logic                  busy;
   logic                  done;
   logic                  wrapped;
   logic [DATA_WIDTH-1:0] checksum;

   modport master (
      input  start, base_addr, word_count, byte_in, byte_valid,
      output byte_ready, regWE, DataAddr, DataIn, busy, done, wrapped, checksum
   );

   modport slave (
      output start, base_addr, word_count, byte_in, byte_valid,
      input  byte_ready, regWE, DataAddr, DataIn, busy, done, wrapped, checksum
   );
endinterface

// File: rtl/mem_loader.sv
// Byte-stream memory loader. It packs incoming bytes big-endian into words and writes them to consecutive addresses.
// Optional feature: define LOADER_CHECKSUM_EN to keep a running XOR of all written words.
module mem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   mem_loader_if.master  bus
);
   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [BCW-1:0]        LAST_BYTE = BCW'(BYTES - 1);
   localparam logic [BCW-1:0]        BYTE_ONE  = BCW'(1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH:0]   WORD_ONE  = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [ADDR_WIDTH:0]   words_q, words_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
   logic                  wrapped_q, wrapped_d;

   // NOTE: every signal gets its default value first, so paths that skip an assignment cannot infer a latch.
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      words_d    = words_q;
      data_d     = data_q;
      byte_cnt_d = byte_cnt_q;
      wrapped_d  = wrapped_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               addr_d     = bus.base_addr;
               count_d    = bus.word_count;
               words_d    = '0;
               byte_cnt_d = '0;
               wrapped_d  = 1'b0;
               state_d    = (bus.word_count == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            // byte_ready is high for the whole COLLECT state, so byte_valid alone marks an accepted byte.
            if (bus.byte_valid) begin
               data_d = (data_q << 8) | DATA_WIDTH'(bus.byte_in);
               if (byte_cnt_q == LAST_BYTE) begin
                  byte_cnt_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  byte_cnt_d = byte_cnt_q + BYTE_ONE;
               end
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + ADDR_ONE;
            words_d = words_q + WORD_ONE;
            if (addr_q == '1) wrapped_d = 1'b1;
            state_d = ((words_q + WORD_ONE) == count_q) ? S_DONE : S_COLLECT;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: reset is synchronous and is sampled only on the clock edge. All state uses non-blocking assignments.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         count_q    <= '0;
         words_q    <= '0;
         data_q     <= '0;
         byte_cnt_q <= '0;
         wrapped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         words_q    <= words_d;
         data_q     <= data_d;
         byte_cnt_q <= byte_cnt_d;
         wrapped_q  <= wrapped_d;
      end
   end

   assign bus.byte_ready = (state_q == S_COLLECT);
   assign bus.regWE      = (state_q == S_WRITE);
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.DataAddr   = addr_q;
   assign bus.DataIn     = data_q;
   assign bus.wrapped    = wrapped_q;

`ifdef LOADER_CHECKSUM_EN
   logic                  start_accept;
   logic [DATA_WIDTH-1:0] checksum_q, checksum_d;

   assign start_accept = (state_q == S_IDLE) && bus.start;

   always_comb begin
      checksum_d = checksum_q;
      if (start_accept)              checksum_d = '0;
      else if (state_q == S_WRITE)   checksum_d = checksum_q ^ data_q;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) checksum_q <= '0;
      else          checksum_q <= checksum_d;
   end

   assign bus.checksum = checksum_q;
`else
   assign bus.checksum = '0;
`endif
endmodule

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader. It pushes expected writes to a scoreboard queue and compares them on every regWE cycle.
// The expected checksum follows LOADER_CHECKSUM_EN in the same way as the design.
module tb_mem_loader;
   localparam int AW = 10;
   localparam int DW = 32;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
   mem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int            errors = 0;
   int            checks = 0;
   int            wr_count = 0;
   wr_t           expq[$];
   logic [7:0]    stim[$];
   logic [DW-1:0] tmem [0:(1<<AW)-1];
   logic [DW-1:0] cks_model;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // The write monitor pops the scoreboard queue and compares each write against the popped entry.
   always @(negedge clk) begin
      if (reset_n && bus.regWE) begin
         wr_count++;
         tmem[bus.DataAddr] = bus.DataIn;
         if (expq.size() == 0) begin
            check("unexpected_write", 1, 0);
         end else begin
            wr_t e;
            e = expq.pop_front();
            check("write_addr", bus.DataAddr, e.addr);
            check("write_data", bus.DataIn, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] count);
      bus.start      = 1'b1;
      bus.base_addr  = base;
      bus.word_count = count;
      tick();
      bus.start      = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      while (!bus.byte_ready && n < 100) begin
         tick();
         n++;
      end
      check("ready_wait", bus.byte_ready, 1);
      tick();
      bus.byte_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (!bus.done && n < 100) begin
         tick();
         n++;
      end
      check("done_seen", bus.done, 1);
      tick();
      check("done_pulse", bus.done, 0);
      check("busy_after", bus.busy, 0);
   endtask

   task automatic run_load(input logic [AW-1:0] base, input int count, input int gap, input bit poke);
      logic [AW-1:0] a;
      wr_t           e;
      int            wr0;
      logic [DW-1:0] exp_cks;
      a = base;
      cks_model = '0;
      for (int w = 0; w < count; w++) begin
         e.addr = a;
         e.data = {stim[4*w], stim[4*w+1], stim[4*w+2], stim[4*w+3]};
         expq.push_back(e);
         cks_model ^= e.data;
         a = a + AW'(1);
      end
      wr0 = wr_count;
      start_load(base, (AW+1)'(count));
      for (int w = 0; w < count; w++) begin
         for (int j = 0; j < 4; j++) begin
            send_byte(stim[4*w+j]);
            if (j == 3) check("we_after_4th", bus.regWE, 1);
            if (!(w == count - 1 && j == 3)) begin
               for (int g = 0; g < gap; g++) begin
                  if (!bus.regWE) check("ready_in_gap", bus.byte_ready, 1);
                  bus.start = poke && (w == 0) && (j == 0) && (g == 0);
                  bus.base_addr = 9;
                  bus.word_count = 5;
                  tick();
                  bus.start = 1'b0;
               end
            end
         end
      end
      wait_done();
      check("write_count", wr_count - wr0, count);
      check("queue_empty", expq.size(), 0);
`ifdef LOADER_CHECKSUM_EN
      exp_cks = cks_model;
`else
      exp_cks = '0;
`endif
      check("checksum", bus.checksum, exp_cks);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, bus.byte_ready, 0);
      check({tag, "_we"}, bus.regWE, 0);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_wrapped"}, bus.wrapped, 0);
      check({tag, "_addr"}, bus.DataAddr, 0);
      check({tag, "_data"}, bus.DataIn, 0);
      check({tag, "_cks"}, bus.checksum, 0);
   endtask

   initial begin
      int wr0;
      reset_n        = 1'b0;
      bus.start      = 1'b0;
      bus.base_addr  = '0;
      bus.word_count = '0;
      bus.byte_in    = '0;
      bus.byte_valid = 1'b0;
      repeat (3) tick();
      check_all_zero("reset");
      reset_n = 1'b1;
      tick();

      // Back-to-back stream: two words at addresses 0 and 1.
      stim = '{8'h20, 8'h1d, 8'h3f, 8'hfc, 8'h20, 8'h08, 8'h00, 8'h0e};
      run_load(0, 2, 0, 1'b0);
      check("t1_mem0", tmem[0], 32'h201d3ffc);
      check("t1_mem1", tmem[1], 32'h2008000e);
      check("t1_wrapped", bus.wrapped, 0);

      // The same stream with 3-cycle valid gaps and a start pulse while busy, which must be ignored.
      run_load(0, 2, 3, 1'b1);
      check("t2_mem1", tmem[1], 32'h2008000e);

      // A zero-length load: done asserts on the next cycle and no write occurs.
      wr0 = wr_count;
      start_load(3, 0);
      check("t3_done", bus.done, 1);
      check("t3_busy", bus.busy, 1);
      check("t3_ready", bus.byte_ready, 0);
      tick();
      check("t3_done_low", bus.done, 0);
      check("t3_writes", wr_count - wr0, 0);

      // An address wrap from 1023 to 0.
      stim = '{8'haa, 8'hbb, 8'hcc, 8'hdd, 8'h11, 8'h22, 8'h33, 8'h44};
      run_load(AW'(1023), 2, 0, 1'b0);
      check("t4_wrapped", bus.wrapped, 1);
      check("t4_mem1023", tmem[1023], 32'haabbccdd);
      check("t4_mem0", tmem[0], 32'h11223344);

      // Reset after two bytes of the first word: no write occurs, then a fresh load succeeds.
      wr0 = wr_count;
      start_load(5, 3);
      send_byte(8'h55);
      send_byte(8'h66);
      reset_n = 1'b0;
      tick();
      check_all_zero("midreset");
      reset_n = 1'b1;
      tick();
      check("t5_no_write", wr_count - wr0, 0);
      stim = '{8'hde, 8'had, 8'hbe, 8'hef};
      run_load(7, 1, 1, 1'b0);
      check("t5_mem7", tmem[7], 32'hdeadbeef);

      // A full-memory load with random data: the address wraps all the way back to the base.
      stim.delete();
      for (int i = 0; i < 4 * (1 << AW); i++) stim.push_back(8'($urandom));
      run_load(100, 1 << AW, 0, 1'b0);
      check("t6_addr_back", bus.DataAddr, 100);
      check("t6_wrapped", bus.wrapped, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
